cpu_clock_ctrl: RTL and testbench

Run/pause/single-step clock-enable generator for the 6502 softcore. Sits directly upstream of `control_unit` and replaces the free-running clock-divider bit that currently drives it. The CPU is clocked from `clk_50mhz` and advances only on cycles where `cpu_ce` is high. Three board buttons control it: run/pause toggle, single step, and speed select. Each button is synchronized, debounced and edge-detected inside the block.

---
 rtl/cpu_clock_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - run/pause/single-step CPU clock-enable generator with debounced buttons
// Optional cycle_count is enabled by defining CPU_CLOCK_CTRL_CYCLE_CNT_EN.
module cpu_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RATE_SHIFT_MAX  = 24
) (
    input  logic        clk_50mhz,
    input  logic        reset_n,
    input  logic        btn_run_n,
    input  logic        btn_step_n,
    input  logic        btn_speed_n,
    output logic        cpu_ce,
    output logic        running,
    output logic [1:0]  speed_sel,
    output logic [15:0] cycle_count
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} mode_e;

    // Bit 0 = run, bit 1 = step, bit 2 = speed.
    logic [2:0]     raw_n;
    logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]     db_q, db_d, db_dly_q, db_dly_d, ev_q, ev_d;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];

    assign raw_n = {btn_speed_n, btn_step_n, btn_run_n};

    // The new level is adopted once the counter has seen the full stable run,
    // and the press pulse is taken from the registered copy of db.
    always_comb begin
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        ev_d     = db_dly_q & ~db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 3'b111;
            sync2_q  <= 3'b111;
            db_q     <= 3'b111;
            db_dly_q <= 3'b111;
            ev_q     <= 3'b000;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            ev_q     <= ev_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    mode_e                    state_q, state_d;
    logic [1:0]               speed_q, speed_d;
    logic [RATE_SHIFT_MAX-1:0] rate_q, rate_d, rate_last;
    logic                     ce_q, ce_d;

    assign rate_last = {RATE_SHIFT_MAX{1'b1}} >> {speed_q, 1'b0};

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        rate_d  = '0;
        ce_d    = 1'b0;
        if (ev_q[2]) begin
            speed_d = speed_q + 2'd1;
        end
        case (state_q)
            PAUSE: begin
                if (ev_q[0]) begin
                    state_d = RUN;
                end else if (ev_q[1]) begin
                    ce_d = 1'b1;
                end
            end
            RUN: begin
                // A run toggle or speed change restarts the cadence without a pulse.
                if (ev_q[0]) begin
                    state_d = PAUSE;
                end else if (!ev_q[2]) begin
                    if (rate_q == rate_last) begin
                        ce_d = 1'b1;
                    end else begin
                        rate_d = rate_q + 1'b1;
                    end
                end
            end
            default: state_d = PAUSE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PAUSE;
            speed_q <= 2'd0;
            rate_q  <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            rate_q  <= rate_d;
            ce_q    <= ce_d;
        end
    end

    assign cpu_ce    = ce_q;
    assign running   = (state_q == RUN);
    assign speed_sel = speed_q;

`ifdef CPU_CLOCK_CTRL_CYCLE_CNT_EN
    logic [15:0] cc_q, cc_d;

    always_comb begin
        cc_d = cc_q + {15'd0, ce_q};
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            cc_q <= 16'd0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cycle_count = cc_q;
`else
    assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed self-checking bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;

    localparam int D   = 4;
    localparam int RSM = 6;
    localparam int B_RUN = 0, B_STEP = 1, B_SPD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  btn_n = 3'b111;
    logic        cpu_ce, running;
    logic [1:0]  speed_sel;
    logic [15:0] cycle_count;

    int tests = 0;
    int fails = 0;
    int ce_total;

    typedef struct {
        int         btn;
        logic       exp_running;
        logic [1:0] exp_speed;
        int         exp_period;
    } vec_t;

    vec_t vecs [6];

    cpu_clock_ctrl #(.DEBOUNCE_CYCLES(D), .RATE_SHIFT_MAX(RSM)) dut (
        .clk_50mhz  (clk),
        .reset_n    (reset_n),
        .btn_run_n  (btn_n[0]),
        .btn_step_n (btn_n[1]),
        .btn_speed_n(btn_n[2]),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .speed_sel  (speed_sel),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) ce_total <= 0;
        else if (cpu_ce) ce_total <= ce_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint exp_cc();
        logic [31:0] t;
        t = ce_total;
`ifdef CPU_CLOCK_CTRL_CYCLE_CNT_EN
        return longint'(t[15:0]);
`else
        return 0;
`endif
    endfunction

    task automatic press(input int b);
        @(negedge clk);
        btn_n[b] = 1'b0;
        repeat (10) @(negedge clk);
        btn_n[b] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic measure(output int period);
        int t_first;
        t_first = -1;
        period  = -1;
        for (int j = 0; j < 300; j++) begin
            @(posedge clk);
            #1;
            if (cpu_ce) begin
                if (t_first < 0) begin
                    t_first = j;
                end else begin
                    period = j - t_first;
                    break;
                end
            end
        end
    endtask

    initial begin
        int n, idx, rise, base, per;
        int ce_at [$];

        vecs[0] = '{B_RUN, 1'b1, 2'd0, 64};
        vecs[1] = '{B_SPD, 1'b1, 2'd1, 16};
        vecs[2] = '{B_SPD, 1'b1, 2'd2, 4};
        vecs[3] = '{B_SPD, 1'b1, 2'd3, 1};
        vecs[4] = '{B_SPD, 1'b1, 2'd0, 64};
        vecs[5] = '{B_RUN, 1'b0, 2'd0, 0};

        repeat (3) @(negedge clk);
        check("reset_cpu_ce", cpu_ce, 0);
        check("reset_running", running, 0);
        check("reset_speed", speed_sel, 0);
        check("reset_cycle_count", cycle_count, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single step in PAUSE
        btn_n[B_STEP] = 1'b0;
        n = 0; idx = -1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ce) begin n++; idx = i; end
            if (i == 9) btn_n[B_STEP] = 1'b1;
        end
        repeat (12) @(negedge clk);
        #1;
        check("step_pulse_count", n, 1);
        check("step_pulse_latency", idx, 8);
        check("step_running", running, 0);
        check("step_cycle_count", cycle_count, exp_cc());

        // Bouncing step button
        @(negedge clk);
        base = ce_total;
        for (int i = 0; i < 20; i++) begin
            btn_n[B_STEP] = ((i >> 1) & 1) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        btn_n[B_STEP] = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_no_ce", ce_total - base, 0);
        check("bounce_running", running, 0);

        // RUN cadence at the slowest rate
        btn_n[B_RUN] = 1'b0;
        rise = -1;
        for (int j = 0; j < 210; j++) begin
            @(posedge clk);
            #1;
            if (running && rise < 0) rise = j;
            if (cpu_ce && rise >= 0) ce_at.push_back(j - rise);
            if (j == 12) btn_n[B_RUN] = 1'b1;
        end
        check("run_rise_latency", rise, 8);
        check("run_ce_count", ce_at.size(), 3);
        if (ce_at.size() == 3) begin
            check("run_ce_1", ce_at[0], 64);
            check("run_ce_2", ce_at[1], 128);
            check("run_ce_3", ce_at[2], 192);
        end
        press(B_RUN);
        check("pause_running", running, 0);
        base = ce_total;
        repeat (100) @(negedge clk);
        check("pause_no_ce", ce_total - base, 0);

        // Table: run, speed stepping with wrap, then pause
        for (int v = 0; v < 6; v++) begin
            press(vecs[v].btn);
            check($sformatf("vec%0d_running", v), running, vecs[v].exp_running);
            check($sformatf("vec%0d_speed", v), speed_sel, vecs[v].exp_speed);
            if (vecs[v].exp_period > 0) begin
                measure(per);
                check($sformatf("vec%0d_period", v), per, vecs[v].exp_period);
            end else begin
                base = ce_total;
                repeat (100) @(negedge clk);
                check($sformatf("vec%0d_no_ce", v), ce_total - base, 0);
            end
        end

        // Run and step together in PAUSE: run wins, step dropped
        @(negedge clk);
        base = ce_total;
        btn_n[B_RUN]  = 1'b0;
        btn_n[B_STEP] = 1'b0;
        repeat (10) @(negedge clk);
        btn_n[B_RUN]  = 1'b1;
        btn_n[B_STEP] = 1'b1;
        repeat (12) @(negedge clk);
        check("runstep_running", running, 1);
        check("runstep_no_ce", ce_total - base, 0);

        press(B_SPD);
        check("pre_reset_speed", speed_sel, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_cpu_ce", cpu_ce, 0);
        check("async_reset_running", running, 0);
        check("async_reset_speed", speed_sel, 0);
        check("async_reset_cycle_count", cycle_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Long run at divisor 1 to wrap cycle_count
        press(B_SPD);
        press(B_SPD);
        press(B_SPD);
        check("wrap_speed", speed_sel, 3);
        press(B_RUN);
        check("wrap_running", running, 1);
        repeat (65600) @(negedge clk);
        press(B_RUN);
        #1;
        check("wrap_paused", running, 0);
        check("wrap_total_over_64k", (ce_total > 65536) ? 1 : 0, 1);
        check("wrap_cycle_count", cycle_count, exp_cc());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
